iex_user_arb: RTL
=================

# iex_user_arb

Request-side arbiter for the IEX function-execution path. It collects function requests from up to eight users and selects one of them round-robin. It presents the winner's 3-bit user code to the function unit through a valid/ack handshake, then holds the grant until the unit signals completion. Its `user` output is the code that downstream interface-select decoding (IS1/IS2 routing) consumes, so it is the originating end of that user-code path.

## Interface
Parameters:
- `N_USERS`, default 8: number of request lines. Legal range is 2..8; user code i corresponds to `req[i]`.
- `TIMEOUT`, default 255: maximum number of SERVE cycles without `done` before the grant is forcibly released. Legal range is 1..255.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  **asynchronous, active-low reset**.
- `req`  in  N_USERS  level request per user; held high until served.
- `user_ack`  in  1  function unit accepts the offered user code.
- `done`  in  1  single-cycle pulse: function unit has finished the current user.
- `user`  out  3  registered code of the granted user.
- `user_valid`  out  1  `user` is being offered (OFFER state only).
- `grant`  out  N_USERS  one-hot of the granted user; nonzero in OFFER and SERVE.
- `busy`  out  1  high in OFFER and SERVE.
- `timeout`  out  1  one-cycle pulse when the SERVE watchdog expires.

## Operation
- FSM states: IDLE, OFFER, SERVE.
- **IDLE**
  - If `req` is nonzero, the picker selects the first asserted request, searching upward from `last+1` modulo `N_USERS`.
  - The winner is registered into `user` and `grant`; the FSM moves to OFFER.
  - If `req` is zero, the FSM stays in IDLE.
- **OFFER**
  - `user_valid` is 1. `user` and `grant` are held stable.
  - `user_ack` = 1 moves the FSM to SERVE and clears the watchdog.
  - If `req[user]` drops while `user_ack` = 0, the offer is withdrawn: return to IDLE, `last` unchanged, `grant` cleared.
  - `user_ack` and a `req[user]` drop in the same cycle: ack wins and the FSM enters SERVE.
  - `done` is ignored in OFFER.
- **SERVE**
  - `user_valid` is 0. The watchdog increments every cycle.
  - `done` = 1: set `last <= user`, clear `grant`, go to IDLE.
  - Watchdog reaches `TIMEOUT` without `done`: pulse `timeout`, set `last <= user`, go to IDLE.
  - `done` in the same cycle as expiry: treat as normal completion, with no `timeout` pulse.
  - Requests that change during SERVE have no effect until IDLE.
- Fairness:
  - A user just served or timed out has the lowest priority in the next pick.
  - A continuously requesting user waits at most `N_USERS-1` grants.
- Reset values: `user` = 0, `user_valid` = 0, `grant` = 0, `busy` = 0, `timeout` = 0, state IDLE, watchdog 0.
  - `last = N_USERS-1`, so the first search starts at user 0.
- Asynchronous reset during OFFER or SERVE drops the grant immediately. No `timeout` pulse is generated.
- Bits of `req` at or above `N_USERS` do not exist. `user` is always below `N_USERS`.

## Timing
- Request latency: `req` sampled high at edge k in IDLE gives `user_valid` = 1 after edge k.
- The handshake completes on the edge where `user_valid && user_ack`.
- Release: `done` at edge m gives `busy` = 0 after edge m. IDLE lasts at least one cycle before the next OFFER, so back-to-back grants are spaced at least 2 cycles apart.
- Timeout fires on the `TIMEOUT`-th SERVE cycle without `done`. `timeout` is high for exactly one cycle, coincident with `busy` falling.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `iex_pkg`:
  - `USER_W = 3`.
  - State enum `arb_state_t` {IDLE, OFFER, SERVE}.
  - Watchdog width constant (8 bits).
- Sub-module `iex_rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `last`.
  - Outputs: `any`, 3-bit index, one-hot vector.
  - It is instantiated once. The FSM, registers and watchdog live in `iex_user_arb`.

## Test plan
- **Reset and first grant:** `rst_n` low, then `req=8'b0000_0101` → after one edge `user=0`, `grant=8'h01`, `user_valid=1`. After ack and `done`, the next grant is `user=2`.
- **Round-robin under saturation:** `req=8'hFF`, ack the cycle after each offer, `done` 3 cycles later → grants 0,1,2,…,7,0 in order. Each `user_valid` rising edge is ≥2 cycles after the preceding `done`.
- **Withdrawn offer:** `req=8'h10`, no ack, drop `req[4]` → back to IDLE, `grant=0`. Then `req=8'h30` → grant `user=4` again, because `last` is unchanged.
- **Simultaneous events:**
  - Ack coincident with the `req[user]` drop → SERVE entered.
  - `done` coincident with watchdog expiry (`TIMEOUT=4`) → no `timeout` pulse.
- **Watchdog:** `TIMEOUT=4`, grant user 3, ack, never `done` → `timeout` high for 1 cycle on the 4th SERVE cycle, and `busy` falls together with it. With `req=8'h0A` the next grant is `user=1`.
- **Reset mid-SERVE:** assert `rst_n=0` asynchronously between edges while serving user 5 → outputs go immediately to their reset values. After release with `req=8'h20`, the grant is `user=5`.

Source files
------------

// File: rtl/iex_pkg.sv
// Shared types and constants for the IEX user-request arbiter.
package iex_pkg;

    // Width of the user code carried to the function unit.
    localparam int USER_W = 3;

    // Width of the SERVE watchdog counter.
    localparam int WD_W = 8;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVE
    } arb_state_t;

endpackage

// File: rtl/iex_user_arb_if.sv
// Request/offer/grant bundle between the users, the arbiter and the function unit.
interface iex_user_arb_if #(
    parameter int N_USERS = 8
);
    import iex_pkg::*;

    logic [N_USERS-1:0] req;
    logic               user_ack;
    logic               done;
    logic [USER_W-1:0]  user;
    logic               user_valid;
    logic [N_USERS-1:0] grant;
    logic               busy;
    logic               timeout;

    // Arbiter side: consumes requests and handshake, drives the grant.
    modport master (
        input  req,
        input  user_ack,
        input  done,
        output user,
        output user_valid,
        output grant,
        output busy,
        output timeout
    );

    // Requester / function-unit side.
    modport slave (
        output req,
        output user_ack,
        output done,
        input  user,
        input  user_valid,
        input  grant,
        input  busy,
        input  timeout
    );

endinterface

// File: rtl/iex_rr_pick.sv
// Combinational round-robin picker: first asserted request above 'last', wrapping.
module iex_rr_pick
    import iex_pkg::*;
#(
    parameter int N_USERS = 8
) (
    input  logic [N_USERS-1:0] req,
    input  logic [USER_W-1:0]  last,
    output logic               any,
    output logic [USER_W-1:0]  idx,
    output logic [N_USERS-1:0] onehot
);

    int w_cand;

    // Walk the users in rotated priority order and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a value unassigned, which would infer a latch.
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        w_cand = 0;
        for (int k = 1; k <= N_USERS; k++) begin
            w_cand = (int'(last) + k) % N_USERS;
            if (!any && req[w_cand]) begin
                any            = 1'b1;
                idx            = USER_W'(w_cand);
                onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iex_user_arb.sv
// Round-robin user arbiter: picks a requester, offers its code, holds the grant until done or watchdog expiry.
module iex_user_arb
    import iex_pkg::*;
#(
    parameter int N_USERS = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    iex_user_arb_if.master bus
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [USER_W-1:0]   r_user;
    logic [USER_W-1:0]   w_user_nxt;
    logic [N_USERS-1:0]  r_grant;
    logic [N_USERS-1:0]  w_grant_nxt;
    logic [USER_W-1:0]   r_last;
    logic [USER_W-1:0]   w_last_nxt;
    logic [WD_W-1:0]     r_wd;
    logic [WD_W-1:0]     w_wd_nxt;
    logic                w_timeout_nxt;
    logic                r_user_valid;
    logic                r_busy;
    logic                r_timeout;

    logic                w_any;
    logic [USER_W-1:0]   w_idx;
    logic [N_USERS-1:0]  w_onehot;

    iex_rr_pick #(
        .N_USERS (N_USERS)
    ) u_pick (
        .req    (bus.req),
        .last   (r_last),
        .any    (w_any),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    // Next-state, next-grant and watchdog decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_user_nxt    = r_user;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_wd_nxt      = r_wd;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_user_nxt  = w_idx;
                    w_grant_nxt = w_onehot;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                // Ack beats a simultaneous request drop.
                if (bus.user_ack) begin
                    w_wd_nxt    = '0;
                    w_state_nxt = SERVE;
                end else if (!bus.req[r_user]) begin
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            SERVE: begin
                // done beats a simultaneous watchdog expiry.
                if (bus.done) begin
                    w_last_nxt  = r_user;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                    w_timeout_nxt = 1'b1;
                    w_last_nxt    = r_user;
                    w_grant_nxt   = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, grant and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_user       <= '0;
            r_grant      <= '0;
            r_last       <= USER_W'(N_USERS - 1);
            r_wd         <= '0;
            r_user_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_user       <= w_user_nxt;
            r_grant      <= w_grant_nxt;
            r_last       <= w_last_nxt;
            r_wd         <= w_wd_nxt;
            r_user_valid <= (w_state_nxt == OFFER);
            r_busy       <= (w_state_nxt != IDLE);
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign bus.user       = r_user;
    assign bus.user_valid = r_user_valid;
    assign bus.grant      = r_grant;
    assign bus.busy       = r_busy;
    assign bus.timeout    = r_timeout;

endmodule
